// File: rtl/boot_ctrl_if.sv
// Loader-side and program-memory-side signals of the boot controller.
// The master modport is the loader/memory environment; the slave modport is boot_ctrl.
interface boot_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              load_start;
  logic [ADDR_W-1:0] load_len;
  logic [31:0]       load_data;
  logic              load_valid;
  logic              load_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output load_start, load_len, load_data, load_valid,
    input  load_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  load_start, load_len, load_data, load_valid,
    output load_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/boot_ctrl.sv
// Boot controller: streams a program image into program memory while holding the CPU in
// reset, then gates the CPU clock enable for halt / single-step / free-run execution.
// Optional feature: define BOOT_CTRL_CHECKSUM_EN to require a trailing 32-bit wrapping-sum
// checksum word after the data words; a mismatch returns to IDLE with a sticky err flag.
module boot_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic       CLK,
  input  logic       reset,
  boot_ctrl_if.slave bus,
  input  logic       run,
  input  logic       step,
  input  logic       halt_req,
  output logic       cpu_reset,
  output logic       cpu_ce,
  output logic [1:0] state,
  output logic       err
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StHalt = 2'd2,
    StRun  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  state_e            state_q, state_d;
  logic              run_q;
  logic              step_ce_q, step_ce_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;

  logic run_rise;
  logic start;
  logic xfer;
  logic last_word;
  logic chk_phase;

  assign run_rise  = run & ~run_q;
  // load_start is ignored while a load is already in progress
  assign start     = bus.load_start & (state_q != StLoad);
  assign xfer      = bus.load_valid & (state_q == StLoad);
  // len_q == 0 encodes a full 2^ADDR_W load, so the last index wraps to all-ones
  assign last_word = (cnt_q == (len_q - AddrOne));

`ifdef BOOT_CTRL_CHECKSUM_EN
  logic        chk_q, chk_d;
  logic [31:0] sum_q, sum_d;
  logic        err_q, err_d;

  assign chk_phase = chk_q;
  assign err       = err_q;
`else
  assign chk_phase = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state logic: load_start has priority over every state's own transitions
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    step_ce_d = 1'b0;
`ifdef BOOT_CTRL_CHECKSUM_EN
    chk_d     = chk_q;
    sum_d     = sum_q;
    err_d     = err_q;
`endif
    if (start) begin
      state_d = StLoad;
      len_d   = bus.load_len;
      cnt_d   = '0;
`ifdef BOOT_CTRL_CHECKSUM_EN
      chk_d   = 1'b0;
      sum_d   = '0;
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
        end
        StLoad: begin
          if (xfer && chk_phase) begin
`ifdef BOOT_CTRL_CHECKSUM_EN
            // Checksum word is consumed but never written to memory
            chk_d   = 1'b0;
            err_d   = (bus.load_data != sum_q);
            state_d = (bus.load_data == sum_q) ? StHalt : StIdle;
`endif
          end else if (xfer) begin
            we_d    = 1'b1;
            addr_d  = cnt_q;
            wdata_d = bus.load_data;
            cnt_d   = cnt_q + AddrOne;
`ifdef BOOT_CTRL_CHECKSUM_EN
            sum_d   = sum_q + bus.load_data;
            if (last_word) chk_d = 1'b1;
`else
            if (last_word) state_d = StHalt;
`endif
          end
        end
        StHalt: begin
          // A coincident run edge wins over a step request
          if (run_rise) begin
            state_d = StRun;
          end else if (step) begin
            step_ce_d = 1'b1;
          end
        end
        StRun: begin
          if (!run || halt_req) state_d = StHalt;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      run_q     <= 1'b0;
      step_ce_q <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
`ifdef BOOT_CTRL_CHECKSUM_EN
      chk_q     <= 1'b0;
      sum_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      run_q     <= run;
      step_ce_q <= step_ce_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
`ifdef BOOT_CTRL_CHECKSUM_EN
      chk_q     <= chk_d;
      sum_q     <= sum_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bus.load_ready = (state_q == StLoad);
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign cpu_reset      = (state_q == StIdle) || (state_q == StLoad);
  assign cpu_ce         = (state_q == StRun) || step_ce_q;
  assign state          = state_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// Self-checking bench for boot_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_boot_ctrl;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int MIdle = 0;
  localparam int MLoad = 1;
  localparam int MHalt = 2;
  localparam int MRun  = 3;
`ifdef BOOT_CTRL_CHECKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       reset;
  logic       run, step, halt_req;
  logic       cpu_reset, cpu_ce, err;
  logic [1:0] state;

  boot_ctrl_if #(.ADDR_W(AW)) bus ();

  boot_ctrl #(.ADDR_W(AW)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .bus      (bus),
    .run      (run),
    .step     (step),
    .halt_req (halt_req),
    .cpu_reset(cpu_reset),
    .cpu_ce   (cpu_ce),
    .state    (state),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: mode, words accepted so far, running sum, pending write
  int          m_mode, m_len, m_got;
  logic [31:0] m_sum, m_data;
  int          m_addr;
  bit          m_err, m_runprev, m_step, m_we;

  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      m_mode = MIdle; m_len = 0; m_got = 0; m_sum = '0; m_err = 0;
      m_runprev = 0; m_step = 0; m_we = 0; m_addr = 0; m_data = '0;
    end else begin
      m_we   = 0;
      m_step = 0;
      if (bus.load_start && m_mode != MLoad) begin
        m_mode = MLoad;
        m_len  = (bus.load_len == 0) ? DEPTH : int'(bus.load_len);
        m_got  = 0;
        m_sum  = '0;
        m_err  = 0;
      end else if (m_mode == MLoad) begin
        if (bus.load_valid) begin
          if (m_got < m_len) begin
            m_we   = 1;
            m_addr = m_got % DEPTH;
            m_data = bus.load_data;
            m_sum  = m_sum + bus.load_data;
            m_got++;
            if (m_got == m_len && !ChkEn) m_mode = MHalt;
          end else if (bus.load_data == m_sum) begin
            m_mode = MHalt;
          end else begin
            m_mode = MIdle;
            m_err  = 1;
          end
        end
      end else if (m_mode == MHalt) begin
        if (run && !m_runprev) m_mode = MRun;
        else if (step)         m_step = 1;
      end else if (m_mode == MRun) begin
        if (!run || halt_req) m_mode = MHalt;
      end
      m_runprev = run;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge CLK) begin
    chk("state",      32'(state),          32'(m_mode));
    chk("cpu_reset",  32'(cpu_reset),      32'(m_mode == MIdle || m_mode == MLoad));
    chk("cpu_ce",     32'(cpu_ce),         32'(m_mode == MRun || m_step));
    chk("load_ready", 32'(bus.load_ready), 32'(m_mode == MLoad));
    chk("mem_we",     32'(bus.mem_we),     32'(m_we));
    chk("mem_addr",   32'(bus.mem_addr),   32'(m_addr));
    chk("mem_wdata",  bus.mem_wdata,       m_data);
    chk("err",        32'(err),            32'(m_err));
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  int nw, nce;

  initial begin
    reset = 1; run = 0; step = 0; halt_req = 0;
    bus.load_start = 0; bus.load_len = '0; bus.load_data = '0; bus.load_valid = 0;
    repeat (3) tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_load_ready", 32'(bus.load_ready), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    reset = 0;
    tick();

    // Three identical words with load_valid held high
    bus.load_start = 1; bus.load_len = 4'd3;
    tick();
    bus.load_start = 0;
    chk("l3_state_load", 32'(state), 1);
    chk("l3_ready", 32'(bus.load_ready), 1);
    bus.load_valid = 1; bus.load_data = 32'h00208033;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("l3_we", 32'(bus.mem_we), 1);
      chk("l3_addr", 32'(bus.mem_addr), i);
      chk("l3_data", bus.mem_wdata, 32'h00208033);
    end
`ifdef BOOT_CTRL_CHECKSUM_EN
    bus.load_data = 32'h00618099;
    tick();
`endif
    bus.load_valid = 0;
    chk("l3_halt", 32'(state), 2);
    chk("l3_cpu_reset", 32'(cpu_reset), 0);
    tick();
    chk("l3_we_off", 32'(bus.mem_we), 0);
    chk("l3_addr_hold", 32'(bus.mem_addr), 2);

    // load_valid toggling every other cycle
    bus.load_start = 1; bus.load_len = 4'd4;
    tick();
    bus.load_start = 0;
    nw = 0;
    for (int i = 0; i < 12; i++) begin
      bus.load_valid = (i % 2 == 0);
      bus.load_data  = (i == 8) ? 32'h40C : 32'h100 + 32'(i);
      tick();
      if (bus.mem_we) begin
        chk("tog_addr", 32'(bus.mem_addr), nw);
        chk("tog_data", bus.mem_wdata, 32'h100 + 32'(2 * nw));
        nw++;
      end
    end
    bus.load_valid = 0;
    chk("tog_count", nw, 4);
    chk("tog_state", 32'(state), 2);

    // Two single steps, then run / halt_req / re-run
    nce = 0;
    for (int k = 0; k < 2; k++) begin
      step = 1;
      tick();
      step = 0;
      if (cpu_ce) nce++;
      tick();
      if (cpu_ce) nce++;
    end
    chk("step_ce_cycles", nce, 2);
    chk("step_state", 32'(state), 2);
    run = 1;
    tick();
    chk("run_state", 32'(state), 3);
    chk("run_ce", 32'(cpu_ce), 1);
    halt_req = 1;
    tick();
    halt_req = 0;
    chk("halt_state", 32'(state), 2);
    chk("halt_ce", 32'(cpu_ce), 0);
    repeat (3) tick();
    chk("halt_stays", 32'(state), 2);
    run = 0;
    tick();
    run = 1;
    tick();
    chk("rerun_state", 32'(state), 3);

    // Reload from RUN with a single word
    bus.load_start = 1; bus.load_len = 4'd1;
    tick();
    bus.load_start = 0;
    chk("l1_state", 32'(state), 1);
    chk("l1_cpu_reset", 32'(cpu_reset), 1);
    chk("l1_cpu_ce", 32'(cpu_ce), 0);
    bus.load_valid = 1; bus.load_data = 32'hABCD0001;
    tick();
`ifdef BOOT_CTRL_CHECKSUM_EN
    tick();
`endif
    bus.load_valid = 0;
    chk("l1_halt", 32'(state), 2);

    // load_len = 0 means a full-depth load
    bus.load_start = 1; bus.load_len = '0;
    tick();
    bus.load_start = 0; bus.load_valid = 1; nw = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.load_data = 32'(i);
      tick();
      if (bus.mem_we) nw++;
    end
`ifdef BOOT_CTRL_CHECKSUM_EN
    bus.load_data = 32'd120;
    tick();
`endif
    bus.load_valid = 0;
    tick();
    chk("len0_count", nw, DEPTH);
    chk("len0_state", 32'(state), 2);
    chk("len0_last_addr", 32'(bus.mem_addr), DEPTH - 1);

`ifdef BOOT_CTRL_CHECKSUM_EN
    // Checksum match, mismatch, then err cleared by the next load_start
    for (int pass = 0; pass < 2; pass++) begin
      bus.load_start = 1; bus.load_len = 4'd2;
      tick();
      bus.load_start = 0; bus.load_valid = 1;
      bus.load_data = 32'd1; tick();
      bus.load_data = 32'd2; tick();
      bus.load_data = (pass == 0) ? 32'd3 : 32'd4; tick();
      bus.load_valid = 0;
      chk("cks_state", 32'(state), (pass == 0) ? 2 : 0);
      chk("cks_err", 32'(err), pass);
    end
    bus.load_start = 1; bus.load_len = 4'd2;
    tick();
    bus.load_start = 0;
    chk("cks_err_clear", 32'(err), 0);
    run = 0;
    bus.load_valid = 1;
    bus.load_data = 32'd1; tick();
    bus.load_data = 32'd2; tick();
    bus.load_data = 32'd3; tick();
    bus.load_valid = 0;
`endif

    // Asynchronous reset after one of four words
    bus.load_start = 1; bus.load_len = 4'd4;
    tick();
    bus.load_start = 0; bus.load_valid = 1; bus.load_data = 32'h55;
    tick();
    reset = 1;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_we", 32'(bus.mem_we), 0);
    chk("arst_addr", 32'(bus.mem_addr), 0);
    chk("arst_wdata", bus.mem_wdata, 0);
    chk("arst_cpu_reset", 32'(cpu_reset), 1);
    chk("arst_cpu_ce", 32'(cpu_ce), 0);
    chk("arst_ready", 32'(bus.load_ready), 0);
    tick();
    tick();
    reset = 0;
    nw = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.mem_we) nw++;
    end
    bus.load_valid = 0;
    chk("arst_no_write", nw, 0);
    chk("arst_idle", 32'(state), 0);

    // Randomized traffic, checked by the every-cycle model comparison
    run = 0;
    for (int c = 0; c < 4000; c++) begin
      bus.load_start = ($urandom_range(0, 29) == 0);
      bus.load_len   = AW'($urandom);
      bus.load_valid = ($urandom_range(0, 2) != 0);
      bus.load_data  = $urandom;
      if (m_mode == MLoad && m_got == m_len && $urandom_range(0, 1) == 0) bus.load_data = m_sum;
      if ($urandom_range(0, 9) == 0) run = ~run;
      step     = ($urandom_range(0, 5) == 0);
      halt_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 799) == 0) begin
        reset = 1;
        tick();
        reset = 0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/boot_ctrl.md
BOOT_CTRL -- requirements
Module: boot_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8: width of the program memory word address; memory depth is 2^ADDR_W words.
REQ-002 Port CLK, in, 1: single system clock; all state changes on its rising edge.
REQ-003 Port reset, in, 1: asynchronous, active-high reset.
REQ-004 Port load_start, in, 1: single-cycle pulse that begins a program load.
REQ-005 Port load_len, in, ADDR_W: number of program words, sampled on load_start; 0 means 2^ADDR_W.
REQ-006 Port load_data, in, 32: program word from the loader source.
REQ-007 Port load_valid, in, 1: load_data is valid.
REQ-008 Port load_ready, out, 1: controller accepts load_data; a transfer occurs when load_valid and load_ready are both high.
REQ-009 Port mem_we, out, 1: program memory write strobe.
REQ-010 Port mem_addr, out, ADDR_W: program memory word address.
REQ-011 Port mem_wdata, out, 32: program memory write data.
REQ-012 Port run, in, 1: level input; a rising edge requests free-running execution.
REQ-013 Port step, in, 1: pulse requesting one CPU clock-enable cycle.
REQ-014 Port halt_req, in, 1: pulse requesting a stop of execution.
REQ-015 Port cpu_reset, out, 1: active-high reset to the processor.
REQ-016 Port cpu_ce, out, 1: processor clock enable.
REQ-017 Port state, out, 2: current state code.
REQ-018 Port err, out, 1: sticky load error flag.

Function
REQ-019 The FSM SHALL have four states with these codes: IDLE=0, LOAD=1, HALT=2, RUN=3.
REQ-020 IDLE: cpu_reset=1, cpu_ce=0, load_ready=0; load_start -> LOAD.
REQ-021 On the load_start edge, the block SHALL latch load_len, clear the write address and running sum, clear err, and assert cpu_reset in any state.
REQ-022 LOAD: load_ready=1, cpu_reset=1, cpu_ce=0; load_start is ignored while in LOAD.
REQ-023 Each transfer SHALL produce mem_we=1 for exactly the following cycle, with mem_addr set to the word index (0,1,2,...) and mem_wdata set to the transferred word; this is a fixed latency of one cycle.
REQ-024 mem_we SHALL be 0 in every other cycle; mem_addr and mem_wdata hold their last values.
REQ-025 The word counter SHALL wrap modulo 2^ADDR_W; with load_len=0, exactly 2^ADDR_W words are accepted.
REQ-026 After the last data word (and the checksum word when REQ-034 applies), the FSM SHALL go to HALT and deassert cpu_reset in the cycle after the final transfer.
REQ-027 HALT: cpu_reset=0, cpu_ce=0; a run rising edge -> RUN; a step pulse drives cpu_ce=1 for exactly one cycle and the FSM stays in HALT.
REQ-028 If a run rising edge and a step pulse coincide in HALT, run SHALL win and no separate step cycle is issued.
REQ-029 RUN: cpu_reset=0, cpu_ce=1; run=0 or halt_req -> HALT, with cpu_ce=0 from the next cycle; step is ignored.
REQ-030 A run rising edge SHALL be detected against a registered copy of run; a run input held high does not re-enter RUN after halt_req.
REQ-031 load_start in HALT or RUN SHALL enter LOAD, with cpu_reset=1 and cpu_ce=0 from the next cycle.

Reset
REQ-032 While reset is high: state=IDLE, cpu_reset=1, cpu_ce=0, load_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, counters and sum=0, registered run=0.
REQ-033 If reset asserts during LOAD, the load SHALL be abandoned; after release the FSM is in IDLE and no write is issued for any word in flight.

Configuration
REQ-034 With BOOT_CTRL_CHECKSUM_EN defined, the block SHALL:
- maintain a 32-bit wrapping sum of the data words;
- accept one extra word after load_len data words as the checksum, without writing it to memory;
- on a match, go to HALT;
- on a mismatch, go to IDLE with err=1, held until the next load_start or reset.
REQ-035 Without BOOT_CTRL_CHECKSUM_EN, no checksum word is accepted, err SHALL be constant 0, and the sum logic is absent.

Verification
REQ-036 Reset, then load_start with load_len=3 and words 0x00208033 x3, load_valid held high -> mem_we pulses at addresses 0,1,2 on consecutive cycles; state=HALT; cpu_reset=0.
REQ-037 load_valid toggled every other cycle during LOAD -> exactly load_len writes, each exactly one cycle after its own transfer, with no duplicates.
REQ-038 In HALT, step pulses 2 times -> exactly 2 cycles of cpu_ce=1; then run 0->1 -> RUN with cpu_ce=1; then halt_req while run=1 -> HALT with cpu_ce=0, staying there until run falls and rises again.
REQ-039 In RUN, load_start with load_len=1 -> cpu_reset=1 and cpu_ce=0 next cycle; state=LOAD; after 1 word, state=HALT.
REQ-040 With BOOT_CTRL_CHECKSUM_EN, words 1,2 then checksum 3 -> HALT, err=0; checksum 4 -> IDLE, err=1; a following load_start clears err.
REQ-041 Reset asserted asynchronously mid-LOAD after 1 of 4 words -> immediate IDLE outputs per REQ-032; no further mem_we.
